// File: rtl/ikaopm_dac_decoder.sv
`default_nettype none
// ikaopm_dac_decoder: receiving end of the OPM serial sound link (YM3012-style DAC front end).
// Deserialises floating-point SO frames and latches signed 16-bit PCM on SH1/SH2 falling edges.
module ikaopm_dac_decoder #(
  parameter int FRAME_LEN    = 16,
  parameter bit EXP0_AS_ZERO = 1'b1
) (
  input  logic               i_EMUCLK,
  input  logic               i_MRST_n,
  input  logic               i_phi1_NCEN_n,
  input  logic               i_SO,
  input  logic               i_SH1,
  input  logic               i_SH2,
  output logic signed [15:0] o_DAC_R,
  output logic signed [15:0] o_DAC_L,
  output logic               o_R_VALID,
  output logic               o_L_VALID,
  output logic               o_FRAME_ERR
);

  localparam logic [4:0] CNT_EXPECT = 5'(FRAME_LEN - 1);
  localparam logic [4:0] CNT_MAX    = 5'd31;

  logic               tick;
  logic [15:0]        sr;
  logic [15:0]        sr_next;
  logic               sh1_z;
  logic               sh2_z;
  logic               edge_r;
  logic               edge_l;
  logic               edge_any;
  logic [4:0]         frame_cnt;
  logic               armed;
  logic [9:0]         mant;
  logic [2:0]         expo;
  logic signed [15:0] base;
  logic signed [15:0] decoded;

  assign tick     = ~i_phi1_NCEN_n;
  assign sr_next  = {i_SO, sr[15:1]};
  assign mant     = sr_next[12:3];
  assign expo     = sr_next[15:13];
  assign edge_r   = sh1_z & ~i_SH1;
  assign edge_l   = sh2_z & ~i_SH2;
  assign edge_any = edge_r | edge_l;

  // Mantissa MSB is an inverted sign; flipping it yields a 10-bit two's complement value.
  always_comb begin
    base    = {{6{~mant[9]}}, ~mant[9], mant[8:0]};
    decoded = base;
    if (expo == 3'd0) begin
      if (EXP0_AS_ZERO) begin
        decoded = '0;
      end
    end else begin
      decoded = base <<< (expo - 3'd1);
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      sr          <= '0;
      sh1_z       <= 1'b1;
      sh2_z       <= 1'b1;
      frame_cnt   <= '0;
      armed       <= 1'b0;
      o_DAC_R     <= '0;
      o_DAC_L     <= '0;
      o_R_VALID   <= 1'b0;
      o_L_VALID   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else if (tick) begin
      sr        <= sr_next;
      sh1_z     <= i_SH1;
      sh2_z     <= i_SH2;
      o_R_VALID <= edge_r;
      o_L_VALID <= edge_l;
      if (edge_r) begin
        o_DAC_R <= decoded;
      end
      if (edge_l) begin
        o_DAC_L <= decoded;
      end
      if (edge_any) begin
        frame_cnt <= '0;
        armed     <= 1'b1;
        // Simultaneous strobes can never both be on a correct frame boundary.
        if ((armed && (frame_cnt != CNT_EXPECT)) || (edge_r && edge_l)) begin
          o_FRAME_ERR <= 1'b1;
        end
      end else if (frame_cnt != CNT_MAX) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

endmodule
`default_nettype wire
